bias_load_ctrl: RTL and testbench
=================================

// Module: bias_load_ctrl
// PURPOSE
//  Writer side of the NPU bias register-file write port (w_index/w_data/w_en).
//  On a start command, fetches num_bias consecutive bias words from the bias SRAM and
//  writes them into the Bias+ReLU SIMD stage as entries 0..num_bias-1.
//  One SRAM read is issued per cycle, so reads are fully pipelined. A done pulse is
//  raised after the last write. Sits between the layer sequencer and the Bias+ReLU SIMD stage.
// PARAMETERS
//  ARRAY_N      16  number of SIMD lanes / bias entries
//  OUT_WIDTH    32  bias word width (equals the consumer's OUT_WIDTH)
//  ADDR_WIDTH   16  bias SRAM word-address width
//  MEM_LATENCY  1   SRAM read latency in cycles (>=1): data is valid MEM_LATENCY cycles after mem_rd_en
// PORTS
//  clk          in   1                     clock, rising edge
//  reset        in   1                     synchronous, active-high
//  start        in   1                     pulse; accepted only in IDLE
//  base_addr    in   ADDR_WIDTH            SRAM address of entry 0; latched on start
//  num_bias     in   $clog2(ARRAY_N)+1     number of entries to load; latched on start
//  busy         out  1                     high in ISSUE, DRAIN and DONE
//  done         out  1                     one-cycle pulse after the final write
//  mem_rd_en    out  1                     SRAM read strobe
//  mem_rd_addr  out  ADDR_WIDTH            SRAM read address
//  mem_rd_data  in   OUT_WIDTH             SRAM read data, MEM_LATENCY cycles after mem_rd_en
//  w_index      out  $clog2(ARRAY_N)+1     bias entry index to the consumer
//  w_data       out  OUT_WIDTH             bias value to the consumer
//  w_en         out  1                     write strobe to the consumer
// BEHAVIOUR
//  Reset:
//   - all outputs are 0 and the state is IDLE.
//   - the read-tracking pipe is cleared, so in-flight reads never produce writes.
//   - reset mid-operation aborts the load; no done pulse is raised.
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   - IDLE: when start=1, latch base_addr and n = min(num_bias, ARRAY_N), and clear rd_cnt and wr_cnt.
//     If n==0, go to DONE; otherwise go to ISSUE.
//   - ISSUE: mem_rd_en=1 and mem_rd_addr = base + rd_cnt (mod 2^ADDR_WIDTH, wrapping silently).
//     rd_cnt increments each cycle. After the read with rd_cnt==n-1, go to DRAIN.
//   - DRAIN: mem_rd_en=0. Stay until the write with wr_cnt==n-1 has been issued, then go to DONE.
//   - DONE: done=1 for exactly one cycle, then go to IDLE.
//   - start in any state other than IDLE is ignored, including start in the DONE cycle.
//  Read tracking: a MEM_LATENCY-deep shift register carries {valid, index} per read.
//   - When the tail is valid, mem_rd_data is registered.
//   - On the next cycle: w_en=1, w_index=index, w_data=data; wr_cnt then increments.
//  Latency (start sampled in cycle T):
//   - first mem_rd_en in T+1; first w_en in T+MEM_LATENCY+2.
//   - last w_en in T+n+MEM_LATENCY+1; done in T+n+MEM_LATENCY+2.
//   - n==0: done in T+1, with no reads and no writes.
//  Writes are issued in strictly increasing index order 0..n-1, with no gaps once the first has occurred.
//  w_index/w_data hold their last values when w_en=0. Entries >= n in the consumer are not touched.
//  num_bias > ARRAY_N is clamped to ARRAY_N.
// STRUCTURE
//  Shared package npu_pkg:
//   - state encoding localparams (S_IDLE, S_ISSUE, S_DRAIN, S_DONE).
//   - the bias index width function clog2(ARRAY_N)+1, shared with the Bias+ReLU SIMD stage.
//  One sub-module, bias_rd_pipe: a MEM_LATENCY-stage valid/index delay line with synchronous clear.
//  The FSM, counters and write register live in the top level.
// TESTING
//  1. base=0x0010, num=16, L=1, SRAM[0x10+i]=i*3 -> 16 consecutive w_en;
//     entry i gets i*3; done at start+19; busy low after done.
//  2. num=0 -> done at start+1; mem_rd_en and w_en never assert.
//  3. base=0xFFFE, num=4 -> addresses FFFE, FFFF, 0000, 0001; w_index 0..3.
//  4. L=3, num=5 -> first w_en at start+5; done at start+10; w_index order 0..4.
//  5. Reset asserted in the cycle of the 3rd w_en -> no further w_en, no done;
//     a new start after reset loads correctly.
//  6. start held high through the whole load, plus num=20 -> exactly one load of 16;
//     a second load begins only after returning to IDLE.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: bias-loader FSM state encoding and the bias entry
// index width helper used by both the bias loader and the Bias+ReLU SIMD stage.
package npu_pkg;

  // Default geometry of the bias path.
  localparam int unsigned NPU_ARRAY_N     = 16;
  localparam int unsigned NPU_OUT_WIDTH   = 32;
  localparam int unsigned NPU_ADDR_WIDTH  = 16;
  localparam int unsigned NPU_MEM_LATENCY = 1;

  // Bias loader FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bias_state_e;

  // Bias index width: one extra bit so a count of ARRAY_N itself is representable.
  function automatic int unsigned bias_idx_width(input int unsigned array_n);
    return unsigned'($clog2(array_n) + 1);
  endfunction

endpackage

// File: rtl/bias_rd_pipe.sv
// Read-tracking delay line for the bias loader.
// Carries {valid, index} for each SRAM read through DEPTH register stages so the
// tail lines up with the cycle in which the SRAM returns that read's data.
// Ports:
//   clk      clock, rising edge
//   clear_i  synchronous clear; drops every in-flight read
//   valid_i  a read is issued this cycle
//   index_i  bias entry index of that read
//   valid_o  tail valid: SRAM data for index_o is on the bus this cycle
//   index_o  tail index
module bias_rd_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] index_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  logic             valid_q [DEPTH];
  logic [IDX_W-1:0] index_q [DEPTH];

  // Shift stage 0 from the inputs, every later stage from its predecessor.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_q[i] <= 1'b0;
        index_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      index_q[0] <= index_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        index_q[i] <= index_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign index_o = index_q[DEPTH-1];

endmodule

// File: rtl/bias_load_ctrl.sv
// Bias loader: on start, streams num_bias consecutive words from the bias SRAM
// (one read per cycle) into the Bias+ReLU SIMD stage as entries 0..n-1, then
// pulses done.
// Ports:
//   clk, reset   clock (rising edge) and synchronous active-high reset
//   start        load request, accepted only when idle
//   base_addr    SRAM address of entry 0 (latched on start)
//   num_bias     entries to load, clamped to ARRAY_N (latched on start)
//   busy         high from the cycle after start through the done cycle
//   done         one-cycle pulse after the final write
//   mem_rd_en    SRAM read strobe
//   mem_rd_addr  SRAM read address
//   mem_rd_data  SRAM read data, MEM_LATENCY cycles after mem_rd_en
//   w_index      bias entry index to the consumer
//   w_data       bias value to the consumer
//   w_en         write strobe to the consumer
module bias_load_ctrl
  import npu_pkg::*;
#(
  parameter int unsigned ARRAY_N     = NPU_ARRAY_N,
  parameter int unsigned OUT_WIDTH   = NPU_OUT_WIDTH,
  parameter int unsigned ADDR_WIDTH  = NPU_ADDR_WIDTH,
  parameter int unsigned MEM_LATENCY = NPU_MEM_LATENCY,
  localparam int unsigned IDX_W      = bias_idx_width(ARRAY_N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [IDX_W-1:0]      num_bias,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [OUT_WIDTH-1:0]  mem_rd_data,
  output logic [IDX_W-1:0]      w_index,
  output logic [OUT_WIDTH-1:0]  w_data,
  output logic                  w_en
);

  localparam logic [IDX_W-1:0] N_MAX = IDX_W'(ARRAY_N);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  bias_state_e           state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IDX_W-1:0]      n_q;
  logic [IDX_W-1:0]      rd_cnt_q;
  logic [IDX_W-1:0]      wr_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_rd_en_q;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_q;
  logic                  w_en_q;
  logic [IDX_W-1:0]      w_index_q;
  logic [OUT_WIDTH-1:0]  w_data_q;

  logic [IDX_W-1:0]      n_d;
  logic                  last_rd;
  logic                  last_wr;
  logic                  tail_valid;
  logic [IDX_W-1:0]      tail_index;

  // Requested entry count, clamped to the number of lanes.
  assign n_d     = (num_bias > N_MAX) ? N_MAX : num_bias;
  assign last_rd = (rd_cnt_q == (n_q - ONE));
  assign last_wr = (wr_cnt_q == (n_q - ONE));

  // Tracks which entry each in-flight read belongs to.
  bias_rd_pipe #(
    .DEPTH (MEM_LATENCY),
    .IDX_W (IDX_W)
  ) u_rd_pipe (
    .clk     (clk),
    .clear_i (reset),
    .valid_i (mem_rd_en_q),
    .index_i (rd_cnt_q),
    .valid_o (tail_valid),
    .index_o (tail_index)
  );

  // FSM, counters, read port and consumer write register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      n_q           <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      w_en_q        <= 1'b0;
      w_index_q     <= '0;
      w_data_q      <= '0;
    end else begin
      done_q <= 1'b0;

      // Returning read data becomes a consumer write one cycle later;
      // index/data hold their last value between writes.
      w_en_q <= tail_valid;
      if (tail_valid) begin
        w_index_q <= tail_index;
        w_data_q  <= mem_rd_data;
      end
      if (w_en_q) begin
        wr_cnt_q <= wr_cnt_q + ONE;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            n_q      <= n_d;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            busy_q   <= 1'b1;
            if (n_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= S_ISSUE;
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= base_addr;
            end
          end
        end

        S_ISSUE: begin
          rd_cnt_q <= rd_cnt_q + ONE;
          if (last_rd) begin
            state_q     <= S_DRAIN;
            mem_rd_en_q <= 1'b0;
          end else begin
            // Address wraps modulo 2^ADDR_WIDTH.
            mem_rd_addr_q <= base_q + ADDR_WIDTH'(rd_cnt_q + ONE);
          end
        end

        S_DRAIN: begin
          if (w_en_q && last_wr) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          // start is deliberately ignored here.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign w_en        = w_en_q;
  assign w_index     = w_index_q;
  assign w_data      = w_data_q;

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Self-checking bench for bias_load_ctrl. Two instances (read latency 1 and 3)
// share the command inputs; each has its own SRAM read model and scoreboard.
module tb_bias_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [4:0]  num_bias;

  logic        busy_0, done_0, rd_en_0, w_en_0;
  logic [15:0] rd_addr_0;
  logic [31:0] rd_data_0, w_data_0;
  logic [4:0]  w_index_0;
  logic        busy_1, done_1, rd_en_1, w_en_1;
  logic [15:0] rd_addr_1;
  logic [31:0] rd_data_1, w_data_1;
  logic [4:0]  w_index_1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Per-instance monitor state.
  int rd_seen [2];
  int w_seen [2];
  int done_seen [2];
  int first_w [2];
  int last_w [2];
  int done_cyc [2];

  // Scoreboard queues: expected read addresses and expected {index, data} writes.
  logic [15:0] aq0 [$];
  logic [15:0] aq1 [$];
  logic [36:0] wq0 [$];
  logic [36:0] wq1 [$];

  logic [31:0] sram [65536];

  // SRAM read models: latency 1 and latency 3; poison value when no read returns.
  logic        pv0 = 1'b0;
  logic [15:0] pa0 = '0;
  logic [2:0]  pv1 = '0;
  logic [15:0] pa1 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pv0    <= rd_en_0;
    pa0    <= rd_addr_0;
    pv1    <= {pv1[1:0], rd_en_1};
    pa1[0] <= rd_addr_1;
    pa1[1] <= pa1[0];
    pa1[2] <= pa1[1];
  end

  assign rd_data_0 = pv0    ? sram[pa0]    : 32'hDEAD_BEEF;
  assign rd_data_1 = pv1[2] ? sram[pa1[2]] : 32'hDEAD_BEEF;

  bias_load_ctrl #(
    .ARRAY_N(16), .OUT_WIDTH(32), .ADDR_WIDTH(16), .MEM_LATENCY(1)
  ) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_bias(num_bias),
    .busy(busy_0), .done(done_0), .mem_rd_en(rd_en_0), .mem_rd_addr(rd_addr_0),
    .mem_rd_data(rd_data_0), .w_index(w_index_0), .w_data(w_data_0), .w_en(w_en_0)
  );

  bias_load_ctrl #(
    .ARRAY_N(16), .OUT_WIDTH(32), .ADDR_WIDTH(16), .MEM_LATENCY(3)
  ) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_bias(num_bias),
    .busy(busy_1), .done(done_1), .mem_rd_en(rd_en_1), .mem_rd_addr(rd_addr_1),
    .mem_rd_data(rd_data_1), .w_index(w_index_1), .w_data(w_data_1), .w_en(w_en_1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy_0 : busy_1;
  endfunction

  function automatic logic [56:0] outs_of(input int d);
    if (d == 0) return {busy_0, done_0, rd_en_0, w_en_0, rd_addr_0, w_index_0, w_data_0};
    return {busy_1, done_1, rd_en_1, w_en_1, rd_addr_1, w_index_1, w_data_1};
  endfunction

  function automatic int aq_size(input int d);
    return (d == 0) ? aq0.size() : aq1.size();
  endfunction

  function automatic int wq_size(input int d);
    return (d == 0) ? wq0.size() : wq1.size();
  endfunction

  function automatic logic [15:0] aq_pop(input int d);
    if (d == 0) return aq0.pop_front();
    return aq1.pop_front();
  endfunction

  function automatic logic [36:0] wq_pop(input int d);
    if (d == 0) return wq0.pop_front();
    return wq1.pop_front();
  endfunction

  task automatic push_exp(input int d, input logic [15:0] base, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      if (d == 0) begin
        aq0.push_back(a);
        wq0.push_back({5'(i), sram[a]});
      end else begin
        aq1.push_back(a);
        wq1.push_back({5'(i), sram[a]});
      end
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      rd_seen[d]   = 0;
      w_seen[d]    = 0;
      done_seen[d] = 0;
      first_w[d]   = -1;
      last_w[d]    = -1;
      done_cyc[d]  = -1;
    end
  endtask

  task automatic mon(input int d, input logic rd_en, input logic [15:0] rd_addr,
                     input logic we, input logic [4:0] widx, input logic [31:0] wdat,
                     input logic dn);
    if (rd_en) begin
      rd_seen[d]++;
      if (aq_size(d) == 0) check_eq($sformatf("rd_unexpected_d%0d", d), 64'(1), 64'(0));
      else check_eq($sformatf("rd_addr_d%0d", d), 64'(rd_addr), 64'(aq_pop(d)));
    end
    if (we) begin
      if (first_w[d] < 0) first_w[d] = cyc;
      last_w[d] = cyc;
      w_seen[d]++;
      if (wq_size(d) == 0) check_eq($sformatf("w_unexpected_d%0d", d), 64'(1), 64'(0));
      else check_eq($sformatf("w_entry_d%0d", d), 64'({widx, wdat}), 64'(wq_pop(d)));
    end
    if (dn) begin
      done_seen[d]++;
      done_cyc[d] = cyc;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rd_en_0, rd_addr_0, w_en_0, w_index_0, w_data_0, done_0);
    mon(1, rd_en_1, rd_addr_1, w_en_1, w_index_1, w_data_1, done_1);
  end

  task automatic fill(input logic [15:0] base, input bit ramp3);
    for (int i = 0; i < 16; i++) begin
      sram[base + 16'(i)] = ramp3 ? 32'(i * 3) : $urandom();
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s_outs_d%0d", name, d), 64'(outs_of(d)), 64'(0));
    end
  endtask

  // One load command; start stays high for cycles T..T+hold.
  task automatic run_load(input string name, input logic [15:0] base,
                          input logic [4:0] num, input int hold);
    int n;
    int t0;
    int c;
    int p [2];
    int loads [2];
    n = (int'(num) > 16) ? 16 : int'(num);
    @(negedge clk); #1;
    clear_mon();
    for (int d = 0; d < 2; d++) begin
      p[d]     = (n == 0) ? 2 : n + lat_of(d) + 3;
      loads[d] = hold / p[d] + 1;
      for (int k = 0; k < loads[d]; k++) push_exp(d, base, n);
    end
    t0 = cyc;
    start = 1'b1;
    base_addr = base;
    num_bias = num;
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("%s_busy_t1_d%0d", name, d), 64'(busy_of(d)), 64'(1));
    repeat (hold) begin @(negedge clk); #1; end
    start = 1'b0;
    c = 0;
    while (c < 400 && (done_seen[0] < loads[0] || done_seen[1] < loads[1])) begin
      @(negedge clk); #1;
      c++;
    end
    if (c >= 400) check_eq({name, "_timeout"}, 64'(0), 64'(1));
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s_writes_d%0d", name, d), 64'(w_seen[d]), 64'(loads[d] * n));
      check_eq($sformatf("%s_reads_d%0d", name, d), 64'(rd_seen[d]), 64'(loads[d] * n));
      check_eq($sformatf("%s_dones_d%0d", name, d), 64'(done_seen[d]), 64'(loads[d]));
      check_eq($sformatf("%s_done_lat_d%0d", name, d), 64'(done_cyc[d] - t0),
               64'((loads[d] - 1) * p[d] + ((n == 0) ? 1 : n + lat_of(d) + 2)));
      if (n > 0) begin
        check_eq($sformatf("%s_first_w_d%0d", name, d), 64'(first_w[d] - t0),
                 64'(lat_of(d) + 2));
        check_eq($sformatf("%s_last_w_d%0d", name, d), 64'(last_w[d] - t0),
                 64'((loads[d] - 1) * p[d] + n + lat_of(d) + 1));
      end
      check_eq($sformatf("%s_wq_left_d%0d", name, d), 64'(wq_size(d)), 64'(0));
      check_eq($sformatf("%s_aq_left_d%0d", name, d), 64'(aq_size(d)), 64'(0));
      check_eq($sformatf("%s_busy_end_d%0d", name, d), 64'(busy_of(d)), 64'(0));
    end
  endtask

  // Reset asserted during the cycle of the latency-1 instance's 3rd write.
  task automatic run_abort();
    int t0;
    int r;
    int c;
    int exp_w;
    fill(16'h0300, 1'b0);
    @(negedge clk); #1;
    clear_mon();
    for (int d = 0; d < 2; d++) push_exp(d, 16'h0300, 16);
    t0 = cyc;
    start = 1'b1;
    base_addr = 16'h0300;
    num_bias = 5'd16;
    @(negedge clk); #1;
    start = 1'b0;
    c = 0;
    while (c < 50 && w_seen[0] < 3) begin
      @(negedge clk); #1;
      c++;
    end
    if (c >= 50) check_eq("abort_timeout", 64'(0), 64'(1));
    r = cyc;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check_zero("abort_reset");
    aq0.delete(); aq1.delete(); wq0.delete(); wq1.delete();
    repeat (30) begin @(negedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      exp_w = r - (t0 + lat_of(d) + 2) + 1;
      if (exp_w < 0) exp_w = 0;
      check_eq($sformatf("abort_writes_d%0d", d), 64'(w_seen[d]), 64'(exp_w));
      check_eq($sformatf("abort_reads_d%0d", d), 64'(rd_seen[d]), 64'(r - t0));
      check_eq($sformatf("abort_dones_d%0d", d), 64'(done_seen[d]), 64'(0));
      check_eq($sformatf("abort_busy_d%0d", d), 64'(busy_of(d)), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_bias = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    fill(16'h0010, 1'b1);
    run_load("full16", 16'h0010, 5'd16, 0);
    run_load("zero", 16'h0020, 5'd0, 0);
    fill(16'hFFFE, 1'b0);
    run_load("wrap", 16'hFFFE, 5'd4, 0);
    fill(16'h0200, 1'b0);
    run_load("five", 16'h0200, 5'd5, 0);
    fill(16'h1234, 1'b0);
    run_load("one", 16'h1234, 5'd1, 0);
    run_abort();
    fill(16'h0300, 1'b0);
    run_load("after_abort", 16'h0300, 5'd7, 0);
    fill(16'h0040, 1'b0);
    run_load("held", 16'h0040, 5'd20, 21);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
